// File: rtl/mac_lookup_client_if.sv
// mac_lookup_client_if
// Groups the request, table and response signals of mac_lookup_client.
//   slave  : the lookup client (takes i_* signals, drives o_* signals)
//   master : the environment, i.e. ingress parsers, MAC table and response sink
// Ports:
//   i_learn_enable       global learn enable
//   i_req_valid/o_req_ready, i_req_sa/i_req_da   per-port request channel
//   o_write_enable, o_port_num, o_MAC_SA/o_MAC_DA, i_port_num   table access
//   o_rsp_valid/i_rsp_ready, o_rsp_src/o_rsp_dst/o_rsp_reflect  response channel
interface mac_lookup_client_if #(
    parameter int pPORTS  = 4,
    parameter int pADRESS = 2,
    parameter int pKEY    = 14
);
    logic                      i_learn_enable;
    logic [pPORTS-1:0]         i_req_valid;
    logic [pPORTS-1:0]         o_req_ready;
    logic [pPORTS*pKEY-1:0]    i_req_sa;
    logic [pPORTS*pKEY-1:0]    i_req_da;
    logic                      o_write_enable;
    logic [pADRESS-1:0]        o_port_num;
    logic [pKEY-1:0]           o_MAC_SA;
    logic [pKEY-1:0]           o_MAC_DA;
    logic [pADRESS-1:0]        i_port_num;
    logic                      o_rsp_valid;
    logic                      i_rsp_ready;
    logic [pADRESS-1:0]        o_rsp_src;
    logic [pADRESS-1:0]        o_rsp_dst;
    logic                      o_rsp_reflect;

    modport slave (
        input  i_learn_enable, i_req_valid, i_req_sa, i_req_da, i_port_num, i_rsp_ready,
        output o_req_ready, o_write_enable, o_port_num, o_MAC_SA, o_MAC_DA,
               o_rsp_valid, o_rsp_src, o_rsp_dst, o_rsp_reflect
    );

    modport master (
        output i_learn_enable, i_req_valid, i_req_sa, i_req_da, i_port_num, i_rsp_ready,
        input  o_req_ready, o_write_enable, o_port_num, o_MAC_SA, o_MAC_DA,
               o_rsp_valid, o_rsp_src, o_rsp_dst, o_rsp_reflect
    );
endinterface

// File: rtl/mac_lookup_client.sv
// mac_lookup_client
// Round-robin arbiter plus learn/lookup sequencer in front of the MAC table.
// One request is granted at a time; the client presents the keys to the table
// for one cycle (learning if enabled), captures the table's registered result
// and hands it back on a valid/ready response channel.
// Ports:
//   iclk  clock
//   irst  asynchronous active-high reset
//   bus   mac_lookup_client_if.slave (request, table and response channels)
//
// state | meaning
// IDLE  | waiting for a request; grant pulse issued combinationally
// ISSUE | keys and port presented to the table, learn strobe if enabled
// WAIT  | table result arrives; response fields captured
// RESP  | response valid, held until accepted
module mac_lookup_client #(
    parameter int pPORTS  = 4,
    parameter int pADRESS = 2,
    parameter int pKEY    = 14
) (
    input  logic                 iclk,
    input  logic                 irst,
    mac_lookup_client_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state_q, state_d;
    logic [pADRESS-1:0]   rr_q, rr_d;
    logic [pADRESS-1:0]   g_q, g_d;
    logic                 learn_q, learn_d;
    logic [pKEY-1:0]      sa_q, sa_d;
    logic [pKEY-1:0]      da_q, da_d;
    logic [pADRESS-1:0]   rsp_src_q, rsp_src_d;
    logic [pADRESS-1:0]   rsp_dst_q, rsp_dst_d;
    logic                 reflect_q, reflect_d;

    logic                 found;
    logic [pADRESS-1:0]   gnt;
    logic [pADRESS-1:0]   idx;
    logic [pPORTS-1:0]    ready;

    // Search from rr upward; the pADRESS-bit add wraps naturally since
    // pPORTS is a power of two.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int i = 0; i < pPORTS; i++) begin
            idx = rr_q + pADRESS'(i);
            if (!found && bus.i_req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        g_d       = g_q;
        learn_d   = learn_q;
        sa_d      = sa_q;
        da_d      = da_q;
        rsp_src_d = rsp_src_q;
        rsp_dst_d = rsp_dst_q;
        reflect_d = reflect_q;
        ready     = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    ready[gnt] = 1'b1;
                    g_d        = gnt;
                    sa_d       = bus.i_req_sa[int'(gnt)*pKEY +: pKEY];
                    da_d       = bus.i_req_da[int'(gnt)*pKEY +: pKEY];
                    learn_d    = bus.i_learn_enable;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // The table read and learn share an edge, so a DA==SA lookup
                // reports the pre-learn entry; it is passed through untouched.
                rsp_dst_d = bus.i_port_num;
                rsp_src_d = g_q;
                reflect_d = (bus.i_port_num == g_q);
                state_d   = RESP;
            end
            RESP: begin
                if (bus.i_rsp_ready) begin
                    rr_d    = g_q + pADRESS'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            g_q       <= '0;
            learn_q   <= 1'b0;
            sa_q      <= '0;
            da_q      <= '0;
            rsp_src_q <= '0;
            rsp_dst_q <= '0;
            reflect_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            g_q       <= g_d;
            learn_q   <= learn_d;
            sa_q      <= sa_d;
            da_q      <= da_d;
            rsp_src_q <= rsp_src_d;
            rsp_dst_q <= rsp_dst_d;
            reflect_q <= reflect_d;
        end
    end

    assign bus.o_req_ready    = ready;
    assign bus.o_write_enable = (state_q == ISSUE) && learn_q;
    assign bus.o_port_num     = g_q;
    assign bus.o_MAC_SA       = sa_q;
    assign bus.o_MAC_DA       = da_q;
    assign bus.o_rsp_valid    = (state_q == RESP);
    assign bus.o_rsp_src      = rsp_src_q;
    assign bus.o_rsp_dst      = rsp_dst_q;
    assign bus.o_rsp_reflect  = reflect_q;

endmodule

// File: tb/tb_mac_lookup_client.sv
// Testbench for mac_lookup_client: directed scenarios with a behavioural
// MAC table model (registered read, write on the same edge).
module tb_mac_lookup_client;

    localparam int P = 4;
    localparam int A = 2;
    localparam int K = 14;

    logic iclk;
    logic irst;
    int   n_chk;
    int   n_fail;

    mac_lookup_client_if #(.pPORTS(P), .pADRESS(A), .pKEY(K)) bus();

    mac_lookup_client #(.pPORTS(P), .pADRESS(A), .pKEY(K)) dut (
        .iclk (iclk),
        .irst (irst),
        .bus  (bus)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Table model: registered lookup, learn on the same edge.
    logic [A-1:0] tbl [0:(1<<K)-1];
    logic         pre_en;
    logic [K-1:0] pre_key;
    logic [A-1:0] pre_val;

    always @(posedge iclk) begin
        bus.i_port_num <= tbl[bus.o_MAC_DA];
        if (bus.o_write_enable) tbl[bus.o_MAC_SA] <= bus.o_port_num;
        if (pre_en) tbl[pre_key] <= pre_val;
    end

    task automatic preload(input logic [K-1:0] key, input logic [A-1:0] val);
        @(posedge iclk); #1;
        pre_en = 1'b1; pre_key = key; pre_val = val;
        @(posedge iclk); #1;
        pre_en = 1'b0;
    endtask

    task automatic set_req(input int p, input logic [K-1:0] sa, input logic [K-1:0] da);
        bus.i_req_sa[p*K +: K] = sa;
        bus.i_req_da[p*K +: K] = da;
    endtask

    task automatic test_reset();
        irst = 1'b1;
        repeat (3) @(negedge iclk);
        n_chk++;
        if ({bus.o_req_ready, bus.o_write_enable, bus.o_port_num, bus.o_MAC_SA, bus.o_MAC_DA,
             bus.o_rsp_valid, bus.o_rsp_src, bus.o_rsp_dst, bus.o_rsp_reflect} !== 41'd0) begin
            n_fail++; $display("FAIL reset_in: outputs not zero during reset");
        end
        irst = 1'b0;
        @(negedge iclk);
        n_chk++;
        if ({bus.o_req_ready, bus.o_write_enable, bus.o_port_num, bus.o_MAC_SA, bus.o_MAC_DA,
             bus.o_rsp_valid, bus.o_rsp_src, bus.o_rsp_dst, bus.o_rsp_reflect} !== 41'd0) begin
            n_fail++; $display("FAIL reset_out: outputs not zero after release");
        end
        @(posedge iclk); #1;
    endtask

    task automatic test_round_robin();
        logic [P-1:0] exp_rdy;
        for (int k = 0; k < P; k++) set_req(k, K'(14'h100 + k), K'(14'h200 + k));
        bus.i_rsp_ready = 1'b1;
        bus.i_req_valid = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            @(negedge iclk);
            exp_rdy = (c % 4 == 0) ? P'(1 << ((c / 4) % 4)) : '0;
            n_chk++;
            if (bus.o_req_ready !== exp_rdy) begin
                n_fail++; $display("FAIL rr_grant c=%0d: got %b expected %b", c, bus.o_req_ready, exp_rdy);
            end
            if (c == 3) begin
                n_chk++;
                if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_src !== 2'd0) begin
                    n_fail++; $display("FAIL rr_rsp0: valid=%b src=%0d expected 1/0", bus.o_rsp_valid, bus.o_rsp_src);
                end
            end
            @(posedge iclk); #1;
            if (c == 16) bus.i_req_valid = '0;
        end
    endtask

    task automatic test_single_learn();
        set_req(2, 14'h0010, 14'h0020);
        bus.i_learn_enable = 1'b1;
        bus.i_req_valid    = 4'b0100;
        @(negedge iclk);
        n_chk++;
        if (bus.o_req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL single_grant: got %b expected 0100", bus.o_req_ready);
        end
        @(posedge iclk); #1;
        bus.i_req_valid    = '0;
        bus.i_learn_enable = 1'b0;   // late change must not affect this transaction
        @(negedge iclk);
        n_chk++;
        if (bus.o_write_enable !== 1'b1 || bus.o_MAC_SA !== 14'h0010 ||
            bus.o_MAC_DA !== 14'h0020 || bus.o_port_num !== 2'd2) begin
            n_fail++; $display("FAIL single_issue: we=%b sa=%h da=%h pn=%0d expected 1/0010/0020/2",
                               bus.o_write_enable, bus.o_MAC_SA, bus.o_MAC_DA, bus.o_port_num);
        end
        @(posedge iclk); #1;
        @(negedge iclk);
        n_chk++;
        if (bus.o_write_enable !== 1'b0 || bus.o_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_wait: we=%b valid=%b expected 0/0", bus.o_write_enable, bus.o_rsp_valid);
        end
        @(posedge iclk); #1;
        @(negedge iclk);
        n_chk++;
        if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_src !== 2'd2 ||
            bus.o_rsp_dst !== 2'd1 || bus.o_rsp_reflect !== 1'b0) begin
            n_fail++; $display("FAIL single_rsp: v=%b src=%0d dst=%0d refl=%b expected 1/2/1/0",
                               bus.o_rsp_valid, bus.o_rsp_src, bus.o_rsp_dst, bus.o_rsp_reflect);
        end
        @(posedge iclk); #1;
        n_chk++;
        if (tbl[14'h0010] !== 2'd2) begin
            n_fail++; $display("FAIL single_learned: table[0010]=%0d expected 2", tbl[14'h0010]);
        end
    endtask

    task automatic test_wrap();
        set_req(0, 14'h0100, 14'h0101);
        set_req(3, 14'h0300, 14'h0301);
        bus.i_req_valid = 4'b1001;
        @(negedge iclk);
        n_chk++;
        if (bus.o_req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL wrap_first: got %b expected 1000", bus.o_req_ready);
        end
        @(posedge iclk); #1;
        bus.i_req_valid = 4'b0001;
        for (int c = 1; c < 4; c++) begin
            @(negedge iclk);
            n_chk++;
            if (bus.o_req_ready !== 4'b0000) begin
                n_fail++; $display("FAIL wrap_busy c=%0d: got %b expected 0000", c, bus.o_req_ready);
            end
            if (c == 3) begin
                n_chk++;
                if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_src !== 2'd3) begin
                    n_fail++; $display("FAIL wrap_rsp3: v=%b src=%0d expected 1/3", bus.o_rsp_valid, bus.o_rsp_src);
                end
            end
            @(posedge iclk); #1;
        end
        @(negedge iclk);
        n_chk++;
        if (bus.o_req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL wrap_second: got %b expected 0001", bus.o_req_ready);
        end
        @(posedge iclk); #1;
        bus.i_req_valid = '0;
        repeat (2) begin @(negedge iclk); @(posedge iclk); #1; end
        @(negedge iclk);
        n_chk++;
        if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_src !== 2'd0) begin
            n_fail++; $display("FAIL wrap_rsp0: v=%b src=%0d expected 1/0", bus.o_rsp_valid, bus.o_rsp_src);
        end
        @(posedge iclk); #1;
    endtask

    task automatic test_reflect();
        preload(14'h0030, 2'd1);
        set_req(1, 14'h0031, 14'h0030);
        bus.i_learn_enable = 1'b0;
        bus.i_req_valid    = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            @(negedge iclk);
            n_chk++;
            if (bus.o_write_enable !== 1'b0) begin
                n_fail++; $display("FAIL reflect_we c=%0d: got %b expected 0", c, bus.o_write_enable);
            end
            if (c == 0) begin
                n_chk++;
                if (bus.o_req_ready !== 4'b0010) begin
                    n_fail++; $display("FAIL reflect_grant: got %b expected 0010", bus.o_req_ready);
                end
            end
            if (c == 3) begin
                n_chk++;
                if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_src !== 2'd1 ||
                    bus.o_rsp_dst !== 2'd1 || bus.o_rsp_reflect !== 1'b1) begin
                    n_fail++; $display("FAIL reflect_rsp: v=%b src=%0d dst=%0d refl=%b expected 1/1/1/1",
                                       bus.o_rsp_valid, bus.o_rsp_src, bus.o_rsp_dst, bus.o_rsp_reflect);
                end
            end
            @(posedge iclk); #1;
            if (c == 0) bus.i_req_valid = '0;
        end
        n_chk++;
        if (tbl[14'h0031] !== 2'd0) begin
            n_fail++; $display("FAIL reflect_nolearn: table[0031]=%0d expected 0", tbl[14'h0031]);
        end
    endtask

    task automatic test_backpressure();
        set_req(0, 14'h0040, 14'h0010);   // 0010 was learned as port 2
        bus.i_learn_enable = 1'b1;
        bus.i_rsp_ready    = 1'b0;
        bus.i_req_valid    = 4'b0001;
        @(negedge iclk);
        n_chk++;
        if (bus.o_req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL bp_grant: got %b expected 0001", bus.o_req_ready);
        end
        @(posedge iclk); #1;
        @(negedge iclk);
        @(posedge iclk); #1;
        @(negedge iclk);
        @(posedge iclk); #1;
        for (int c = 0; c < 10; c++) begin
            @(negedge iclk);
            n_chk++;
            if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_src !== 2'd0 || bus.o_rsp_dst !== 2'd2 ||
                bus.o_rsp_reflect !== 1'b0 || bus.o_req_ready !== 4'b0000) begin
                n_fail++; $display("FAIL bp_hold c=%0d: v=%b src=%0d dst=%0d refl=%b rdy=%b expected 1/0/2/0/0000",
                                   c, bus.o_rsp_valid, bus.o_rsp_src, bus.o_rsp_dst, bus.o_rsp_reflect, bus.o_req_ready);
            end
            @(posedge iclk); #1;
        end
        bus.i_rsp_ready = 1'b1;
        @(negedge iclk);
        n_chk++;
        if (bus.o_rsp_valid !== 1'b1 || bus.o_req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL bp_accept: v=%b rdy=%b expected 1/0000", bus.o_rsp_valid, bus.o_req_ready);
        end
        @(posedge iclk); #1;
        @(negedge iclk);
        n_chk++;
        if (bus.o_req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL bp_regrant: got %b expected 0001", bus.o_req_ready);
        end
        @(posedge iclk); #1;
        bus.i_req_valid = '0;
        repeat (2) begin @(negedge iclk); @(posedge iclk); #1; end
        @(negedge iclk);
        n_chk++;
        if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_dst !== 2'd2) begin
            n_fail++; $display("FAIL bp_rsp2: v=%b dst=%0d expected 1/2", bus.o_rsp_valid, bus.o_rsp_dst);
        end
        @(posedge iclk); #1;
    endtask

    task automatic test_reset_mid();
        set_req(1, 14'h0050, 14'h0051);
        bus.i_learn_enable = 1'b1;
        bus.i_req_valid    = 4'b0010;
        @(negedge iclk);
        n_chk++;
        if (bus.o_req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL rst_grant: got %b expected 0010", bus.o_req_ready);
        end
        @(posedge iclk); #1;
        bus.i_req_valid = '0;
        @(negedge iclk);
        n_chk++;
        if (bus.o_write_enable !== 1'b1) begin
            n_fail++; $display("FAIL rst_issue_we: got %b expected 1", bus.o_write_enable);
        end
        @(posedge iclk); #1;
        irst = 1'b1;
        #1;
        n_chk++;
        if ({bus.o_req_ready, bus.o_write_enable, bus.o_port_num, bus.o_MAC_SA, bus.o_MAC_DA,
             bus.o_rsp_valid, bus.o_rsp_src, bus.o_rsp_dst, bus.o_rsp_reflect} !== 41'd0) begin
            n_fail++; $display("FAIL rst_mid: outputs not zero; we=%b pn=%0d sa=%h da=%h",
                               bus.o_write_enable, bus.o_port_num, bus.o_MAC_SA, bus.o_MAC_DA);
        end
        @(negedge iclk);
        irst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge iclk); #1;
            @(negedge iclk);
            n_chk++;
            if (bus.o_rsp_valid !== 1'b0 || bus.o_write_enable !== 1'b0) begin
                n_fail++; $display("FAIL rst_quiet c=%0d: v=%b we=%b expected 0/0", c, bus.o_rsp_valid, bus.o_write_enable);
            end
        end
        @(posedge iclk); #1;
        set_req(0, 14'h0060, 14'h0061);
        set_req(3, 14'h0070, 14'h0071);
        bus.i_req_valid = 4'b1001;
        @(negedge iclk);
        n_chk++;
        if (bus.o_req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL rst_regrant: got %b expected 0001", bus.o_req_ready);
        end
        @(posedge iclk); #1;
        bus.i_req_valid = '0;
        repeat (3) begin @(negedge iclk); @(posedge iclk); #1; end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        irst   = 1'b1;
        pre_en = 1'b0; pre_key = '0; pre_val = '0;
        bus.i_learn_enable = 1'b0;
        bus.i_req_valid    = '0;
        bus.i_req_sa       = '0;
        bus.i_req_da       = '0;
        bus.i_rsp_ready    = 1'b1;
        test_reset();
        preload(14'h0020, 2'd1);
        test_round_robin();
        test_single_learn();
        test_wrap();
        test_reflect();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mac_lookup_client.md
# mac_lookup_client

Ingress-side client of the MAC learning/forwarding table. It collects header lookups (source and destination MAC keys) from pPORTS ingress ports and arbitrates between them round-robin. For each granted request it drives one learn-plus-lookup cycle into the table, captures the table's registered read result, and returns the destination port to the requester over a valid/ready response channel. It sits between the per-port header parsers and the table.

## Interface
Parameters:
- pPORTS, 4: number of ingress ports (power of two, 2..16).
- pADRESS, 2: port number width; equals $clog2(pPORTS).
- pKEY, 14: MAC key width (table index).

Ports:
- iclk  input  1  clock.
- irst  input  1  reset, asynchronous, active-high.
- i_learn_enable  input  1  global learning enable; sampled at grant.
- i_req_valid  input  pPORTS  per-port request valid.
- o_req_ready  output  pPORTS  one-hot grant pulse; request consumed when valid and ready are both high.
- i_req_sa  input  pPORTS*pKEY  per-port source key; port k occupies bits [k*pKEY +: pKEY].
- i_req_da  input  pPORTS*pKEY  per-port destination key; same packing as i_req_sa.
- o_write_enable  output  1  to table: learn strobe.
- o_port_num  output  pADRESS  to table: port to learn (the requester index).
- o_MAC_SA  output  pKEY  to table: source key.
- o_MAC_DA  output  pKEY  to table: destination key.
- i_port_num  input  pADRESS  from table: registered lookup result, valid 1 cycle after the key is presented.
- o_rsp_valid  output  1  response valid.
- i_rsp_ready  input  1  response accepted.
- o_rsp_src  output  pADRESS  requester port index.
- o_rsp_dst  output  pADRESS  destination port returned by the table.
- o_rsp_reflect  output  1  high when o_rsp_dst == o_rsp_src; the frame must be dropped.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset enters IDLE.
- Round-robin pointer rr (pADRESS bits):
  - Search starts at rr and wraps modulo pPORTS.
  - The first port with i_req_valid set wins and becomes grant g.
  - After the response completes, rr <= g+1, with g = pPORTS-1 wrapping rr to 0.
- IDLE:
  - If any i_req_valid is set, o_req_ready[g]=1 for this cycle only (combinational from state, rr and i_req_valid).
  - Latch g, SA[g], DA[g] and i_learn_enable.
  - Go to ISSUE.
  - If no request is valid, o_req_ready=0 and the FSM stays in IDLE.
- ISSUE:
  - Registered table outputs hold o_MAC_SA, o_MAC_DA and o_port_num=g.
  - o_write_enable equals the latched learn enable.
  - Go to WAIT.
- WAIT:
  - o_write_enable=0; the key outputs hold their values.
  - Capture i_port_num into o_rsp_dst.
  - Set o_rsp_src=g and compute o_rsp_reflect.
  - Go to RESP.
- RESP:
  - o_rsp_valid=1; all response fields are stable until i_rsp_ready.
  - On i_rsp_ready, advance rr and go to IDLE.
- When DA==SA, the table returns the pre-learn value, because the read and write share the same edge. o_rsp_dst reports that value unmodified.
- Only one transaction is in flight; requests arriving in any state other than IDLE wait, and o_req_ready stays 0.
- i_learn_enable changes after the grant have no effect on the current transaction.

## Timing
- Reset values:
  - state IDLE, rr=0.
  - o_req_ready=0, o_write_enable=0, o_port_num=0, o_MAC_SA=0, o_MAC_DA=0.
  - o_rsp_valid=0, o_rsp_src=0, o_rsp_dst=0, o_rsp_reflect=0.
- Reset mid-transaction: the transaction is abandoned with no response and no further o_write_enable; after release the bench observes exactly the reset values.
- Latency:
  - Grant in cycle T.
  - o_write_enable and keys in cycle T+1.
  - Result captured at the end of T+2.
  - o_rsp_valid in cycle T+3.
- Minimum 4 cycles per lookup, when i_rsp_ready is held high.
- o_write_enable is high for exactly one cycle per learn-enabled transaction and never in any other state.
- Backpressure: RESP is held indefinitely while i_rsp_ready=0; the next grant happens no earlier than the cycle after acceptance.
- Width rules:
  - rr and g wrap modulo pPORTS with no overflow handling beyond the natural pADRESS-bit wrap.
  - o_rsp_reflect is a full pADRESS-bit equality compare.

## Test plan
- Single request, learn: port 2 requests SA=0x0010, DA=0x0020 with learn on; model table maps 0x0020->1. Required: o_req_ready=0100 at T; o_write_enable=1 with o_MAC_SA=0x0010 and o_port_num=2 at T+1; o_rsp_valid at T+3 with src=2, dst=1, reflect=0.
- Round-robin fairness: all four ports valid continuously, i_rsp_ready=1. Required: grants 0,1,2,3,0 with one grant every 4 cycles.
- Wrap from pointer: rr=3 after port 2's response, requests on ports 0 and 3. Required: port 3 wins, then port 0.
- Reflect, learn off: port 1 requests with DA mapped to 1 and i_learn_enable=0. Required: o_write_enable stays 0 throughout; response dst=1, reflect=1.
- Backpressure: i_rsp_ready low for 10 cycles in RESP while port 0 is valid. Required: o_rsp_valid and all fields stable; o_req_ready=0 the whole time; grant in the cycle after acceptance.
- Reset mid-operation: assert irst in the WAIT state. Required: all outputs drop to their reset values immediately; no response follows; the first grant after release goes to port 0 when ports 0 and 3 are valid.
